extended_hamming_scrubber: RTL and testbench

- Background scrubber for an extended-Hamming-protected memory.
- Walks every address in turn with a read, then checks and corrects the returned word and code.
- On a correctable (single-bit) error, writes back the corrected data with a re-encoded code. On an uncorrectable (double-bit) error, reports it and leaves the word untouched.
- Sits next to the memory and competes with functional traffic through a request/grant port to the memory arbiter. Correction and encoding use the team's extended_hamming corrector and encoder blocks.

---
 rtl/extended_hamming_scrubber.sv | 172 +++++++++++++++++
 tb/tb_extended_hamming_scrubber.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extended_hamming_scrubber.sv
// Background scrubber: reads each word, fixes single-bit errors by write-back, reports double-bit errors.
// Error report and counter update land one cycle after the read response; request is held until grant.
module extended_hamming_scrubber #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 64,
  parameter int COUNTER_WIDTH  = 8,
  localparam int PARITY_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH) + 1) + 1,
  localparam int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     clear_counters,
  output logic                     memory_request,
  input  logic                     memory_grant,
  output logic                     memory_write,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0]    memory_write_data,
  output logic [PARITY_WIDTH-1:0]  memory_write_code,
  input  logic                     memory_read_valid,
  input  logic [DATA_WIDTH-1:0]    memory_read_data,
  input  logic [PARITY_WIDTH-1:0]  memory_read_code,
  output logic                     error_valid,
  output logic                     error_uncorrectable,
  output logic [ADDRESS_WIDTH-1:0] error_address,
  output logic [COUNTER_WIDTH-1:0] corrected_count,
  output logic [COUNTER_WIDTH-1:0] uncorrectable_count,
  output logic                     pass_done
);

  localparam int HAM_R    = PARITY_WIDTH - 1;
  localparam int CODE_LEN = DATA_WIDTH + HAM_R;
  localparam int IW       = (SCRUB_INTERVAL > 0) ? $clog2(SCRUB_INTERVAL + 1) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_RESP, S_WRITE, S_NEXT} state_t;

  // Data bits occupy the non-power-of-two codeword positions in ascending order;
  // code[HAM_R] is the overall parity that makes the whole codeword even.
  function automatic logic [HAM_R-1:0] hamming_bits(input logic [DATA_WIDTH-1:0] d);
    logic [HAM_R-1:0] p;
    int j;
    p = '0;
    j = 0;
    for (int pos = 1; pos <= CODE_LEN; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int i = 0; i < HAM_R; i++) begin
          if (pos[i]) p[i] = p[i] ^ d[j];
        end
        j++;
      end
    end
    return p;
  endfunction

  function automatic logic [PARITY_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [HAM_R-1:0] p;
    p = hamming_bits(d);
    return {^{d, p}, p};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] flip_mask(input logic [HAM_R-1:0] syn);
    logic [DATA_WIDTH-1:0] m;
    int j;
    m = '0;
    j = 0;
    for (int pos = 1; pos <= CODE_LEN; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (int'(syn) == pos) m[j] = 1'b1;
        j++;
      end
    end
    return m;
  endfunction

  state_t                    state, state_nxt;
  logic [ADDRESS_WIDTH-1:0]  addr;
  logic [IW-1:0]             interval_cnt;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic [PARITY_WIDTH-1:0]   wb_code;

  logic [HAM_R-1:0]          rd_syndrome;
  logic                      rd_parity_odd;
  logic                      rd_single;
  logic                      rd_double;
  logic [DATA_WIDTH-1:0]     rd_corrected;
  logic                      resp_take;

  always_comb begin
    rd_syndrome   = memory_read_code[HAM_R-1:0] ^ hamming_bits(memory_read_data);
    rd_parity_odd = ^{memory_read_data, memory_read_code};
    rd_corrected  = memory_read_data ^ flip_mask(rd_syndrome);
    // Even overall parity with a nonzero syndrome, or a syndrome pointing past the codeword, cannot be repaired.
    rd_double     = (rd_syndrome != '0) && (!rd_parity_odd || (int'(rd_syndrome) > CODE_LEN));
    rd_single     = rd_parity_odd && !rd_double;
    resp_take     = (state == S_RESP) && memory_read_valid;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (enable) state_nxt = S_WAIT;
      S_WAIT:  if (interval_cnt == '0) state_nxt = S_READ;
      S_READ:  if (memory_grant) state_nxt = S_RESP;
      S_RESP:  if (memory_read_valid) state_nxt = rd_single ? S_WRITE : S_NEXT;
      S_WRITE: if (memory_grant) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = enable ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    memory_request    = (state == S_READ) || (state == S_WRITE);
    memory_write      = (state == S_WRITE);
    pass_done         = (state == S_NEXT) && (addr == LAST_ADDR);
    memory_address    = addr;
    memory_write_data = wb_data;
    memory_write_code = wb_code;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr                <= '0;
      interval_cnt        <= '0;
      wb_data             <= '0;
      wb_code             <= '0;
      error_valid         <= 1'b0;
      error_uncorrectable <= 1'b0;
      error_address       <= '0;
    end else begin
      error_valid <= 1'b0;
      if ((state_nxt == S_WAIT) && (state != S_WAIT))
        interval_cnt <= IW'(SCRUB_INTERVAL);
      else if ((state == S_WAIT) && (interval_cnt != '0))
        interval_cnt <= interval_cnt - 1'b1;
      if (resp_take) begin
        wb_data <= rd_corrected;
        wb_code <= encode(rd_corrected);
        if (rd_single || rd_double) begin
          error_valid         <= 1'b1;
          error_uncorrectable <= rd_double;
          error_address       <= addr;
        end
      end
      if (state == S_NEXT)
        addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      corrected_count     <= '0;
      uncorrectable_count <= '0;
    end else if (clear_counters) begin
      corrected_count     <= '0;
      uncorrectable_count <= '0;
    end else begin
      if (resp_take && rd_single && (corrected_count != '1))
        corrected_count <= corrected_count + 1'b1;
      if (resp_take && rd_double && (uncorrectable_count != '1))
        uncorrectable_count <= uncorrectable_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_extended_hamming_scrubber.sv
// Directed bench for extended_hamming_scrubber: 4-word memory model, 1-cycle read latency,
// hand-computed codewords (00->00, A5->03, 3C->12, FF->03).
module tb_extended_hamming_scrubber;

  logic       clock = 1'b0;
  logic       resetn;
  logic       enable;
  logic       clear_counters;
  logic       memory_request;
  logic       memory_grant;
  logic       memory_write;
  logic [1:0] memory_address;
  logic [7:0] memory_write_data;
  logic [4:0] memory_write_code;
  logic       memory_read_valid = 1'b0;
  logic [7:0] memory_read_data  = 8'h00;
  logic [4:0] memory_read_code  = 5'h00;
  logic       error_valid;
  logic       error_uncorrectable;
  logic [1:0] error_address;
  logic [1:0] corrected_count;
  logic [1:0] uncorrectable_count;
  logic       pass_done;

  extended_hamming_scrubber #(
    .DATA_WIDTH(8), .DEPTH(4), .SCRUB_INTERVAL(0), .COUNTER_WIDTH(2)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .clear_counters(clear_counters),
    .memory_request(memory_request), .memory_grant(memory_grant), .memory_write(memory_write),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_write_code(memory_write_code), .memory_read_valid(memory_read_valid),
    .memory_read_data(memory_read_data), .memory_read_code(memory_read_code),
    .error_valid(error_valid), .error_uncorrectable(error_uncorrectable),
    .error_address(error_address), .corrected_count(corrected_count),
    .uncorrectable_count(uncorrectable_count), .pass_done(pass_done)
  );

  always #5 clock = ~clock;

  logic [7:0] mem_d [4];
  logic [4:0] mem_c [4];
  logic [1:0] rd_log [$];
  int         wr_cnt = 0;
  logic [1:0] wr_addr_last = 2'd0;
  logic [7:0] wr_data_last = 8'h00;
  logic [4:0] wr_code_last = 5'h00;
  int         err_cnt = 0;
  logic       last_unc = 1'b0;
  logic [1:0] last_addr = 2'd0;
  int         pass_hi_cnt = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  // Memory responder: accepts on request&grant, answers reads in the following cycle.
  always @(posedge clock) begin
    logic       fire;
    logic       wr;
    logic [1:0] a;
    logic [7:0] wd;
    logic [4:0] wc;
    fire = memory_request && memory_grant && resetn;
    wr   = memory_write;
    a    = memory_address;
    wd   = memory_write_data;
    wc   = memory_write_code;
    #1;
    memory_read_valid = 1'b0;
    if (fire === 1'b1) begin
      if (wr) begin
        mem_d[a] = wd;
        mem_c[a] = wc;
        wr_cnt++;
        wr_addr_last = a;
        wr_data_last = wd;
        wr_code_last = wc;
      end else begin
        memory_read_valid = 1'b1;
        memory_read_data  = mem_d[a];
        memory_read_code  = mem_c[a];
        rd_log.push_back(a);
      end
    end
  end

  always @(negedge clock) begin
    if (error_valid === 1'b1) begin
      err_cnt++;
      last_unc  = error_uncorrectable;
      last_addr = error_address;
    end
    if (pass_done === 1'b1) pass_hi_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pass_done();
    int n;
    n = 0;
    @(negedge clock);
    while (pass_done !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    #2;
    check("pass_done_reached", pass_done, 1'b1);
  endtask

  task automatic wait_req(input logic w, input logic [1:0] a);
    int n;
    n = 0;
    while (!(memory_request === 1'b1 && memory_write === w && memory_address === a) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("request_seen", {memory_request, memory_write, memory_address}, {1'b1, w, a});
  endtask

  task automatic one_pass();
    rd_log.delete();
    enable = 1'b1;
    wait_pass_done();
    enable = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    enable = 1'b0;
    clear_counters = 1'b0;
    memory_grant = 1'b1;
    mem_d[0] = 8'h00; mem_c[0] = 5'h00;
    mem_d[1] = 8'hA5; mem_c[1] = 5'h03;
    mem_d[2] = 8'h3C; mem_c[2] = 5'h12;
    mem_d[3] = 8'hFF; mem_c[3] = 5'h03;
    repeat (2) @(negedge clock);

    check("rst_request", memory_request, 1'b0);
    check("rst_write", memory_write, 1'b0);
    check("rst_address", memory_address, 2'd0);
    check("rst_error_valid", error_valid, 1'b0);
    check("rst_corrected", corrected_count, 2'd0);
    check("rst_uncorrectable", uncorrectable_count, 2'd0);
    check("rst_pass_done", pass_done, 1'b0);
    resetn = 1'b1;
    @(negedge clock);

    // Clean memory, two back-to-back passes.
    enable = 1'b1;
    wait_pass_done();
    wait_pass_done();
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("clean_read_count", rd_log.size(), 8);
    for (int i = 0; i < 8; i++) check("clean_read_addr", rd_log[i], i % 4);
    check("clean_pass_pulses", pass_hi_cnt, 2);
    check("clean_writes", wr_cnt, 0);
    check("clean_errors", err_cnt, 0);
    check("clean_corrected", corrected_count, 2'd0);

    // Data bit 3 flipped at address 2.
    mem_d[2] = 8'h34;
    one_pass();
    check("single_err_cnt", err_cnt, 1);
    check("single_err_unc", last_unc, 1'b0);
    check("single_err_addr", last_addr, 2'd2);
    check("single_corrected", corrected_count, 2'd1);
    check("single_wr_cnt", wr_cnt, 1);
    check("single_wr_addr", wr_addr_last, 2'd2);
    check("single_wr_data", wr_data_last, 8'h3C);
    check("single_wr_code", wr_code_last, 5'h12);
    one_pass();
    check("single_fixed_err_cnt", err_cnt, 1);
    check("single_fixed_wr_cnt", wr_cnt, 1);
    check("error_address_held", error_address, 2'd2);

    // Bits 0 and 5 flipped at address 1: reported every pass, never written.
    mem_d[1] = 8'h84;
    one_pass();
    check("double_err_cnt", err_cnt, 2);
    check("double_err_unc", last_unc, 1'b1);
    check("double_err_addr", last_addr, 2'd1);
    check("double_unc_count", uncorrectable_count, 2'd1);
    check("double_no_write", wr_cnt, 1);
    check("double_unc_out", error_uncorrectable, 1'b1);
    one_pass();
    check("double_again_err_cnt", err_cnt, 3);
    check("double_again_unc_count", uncorrectable_count, 2'd2);
    check("double_again_no_write", wr_cnt, 1);
    mem_d[1] = 8'hA5;

    // Code bit 2 flipped at address 1; enable dropped the cycle after the read grant.
    mem_c[1] = 5'h07;
    rd_log.delete();
    enable = 1'b1;
    wait_req(1'b0, 2'd1);
    @(negedge clock);
    enable = 1'b0;
    repeat (15) @(negedge clock);
    check("drop_wr_cnt", wr_cnt, 2);
    check("drop_wr_addr", wr_addr_last, 2'd1);
    check("drop_wr_data", wr_data_last, 8'hA5);
    check("drop_wr_code", wr_code_last, 5'h03);
    check("drop_corrected", corrected_count, 2'd2);
    check("drop_reads", rd_log.size(), 2);
    check("drop_idle_request", memory_request, 1'b0);
    enable = 1'b1;
    n = 0;
    while (rd_log.size() < 3 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("resume_read_addr", rd_log[2], 2'd2);
    wait_pass_done();
    enable = 1'b0;
    repeat (3) @(negedge clock);

    // Grant withheld for 10 cycles on the read and on the write-back of address 3.
    mem_d[3] = 8'h7F;
    rd_log.delete();
    enable = 1'b1;
    wait_req(1'b0, 2'd3);
    memory_grant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_read_hold", {memory_request, memory_write, memory_address}, {1'b1, 1'b0, 2'd3});
    end
    memory_grant = 1'b1;
    wait_req(1'b1, 2'd3);
    memory_grant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_write_hold",
            {memory_request, memory_write, memory_address, memory_write_data, memory_write_code},
            {1'b1, 1'b1, 2'd3, 8'hFF, 5'h03});
    end
    memory_grant = 1'b1;
    wait_pass_done();
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("stall_read_count", rd_log.size(), 4);
    check("stall_wr_cnt", wr_cnt, 3);
    check("stall_mem_fixed", mem_d[3], 8'hFF);
    check("stall_corrected", corrected_count, 2'd3);

    // Two more corrections: counter stays saturated.
    mem_d[0] = 8'h01;
    mem_d[2] = 8'h7C;
    one_pass();
    check("sat_corrected", corrected_count, 2'd3);
    check("sat_err_cnt", err_cnt, 7);
    check("sat_wr_cnt", wr_cnt, 5);
    check("sat_mem0", mem_d[0], 8'h00);
    check("sat_mem2", mem_d[2], 8'h3C);

    // clear_counters in the same cycle as an increment.
    mem_d[1] = 8'hB5;
    rd_log.delete();
    enable = 1'b1;
    wait_req(1'b0, 2'd1);
    @(negedge clock);
    clear_counters = 1'b1;
    @(negedge clock);
    clear_counters = 1'b0;
    check("clr_error_valid", {error_valid, error_uncorrectable, error_address}, {1'b1, 1'b0, 2'd1});
    check("clr_corrected", corrected_count, 2'd0);
    check("clr_uncorrectable", uncorrectable_count, 2'd0);
    wait_pass_done();
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("clr_wr_cnt", wr_cnt, 6);
    check("clr_mem1", mem_d[1], 8'hA5);
    check("clr_corrected_after", corrected_count, 2'd0);

    // Asynchronous reset while a read request waits for grant.
    mem_d[1] = 8'h84;
    one_pass();
    check("pre_reset_unc", uncorrectable_count, 2'd1);
    memory_grant = 1'b0;
    enable = 1'b1;
    wait_req(1'b0, 2'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_request", memory_request, 1'b0);
    check("arst_unc_count", uncorrectable_count, 2'd0);
    check("arst_error_address", error_address, 2'd0);
    enable = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    memory_grant = 1'b1;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
